chord_debounce: RTL and testbench

CHORD_DEBOUNCE -- requirements
Module: chord_debounce

---
 rtl/chord_debounce.sv | 141 ++++++++++++++
 tb/tb_chord_debounce.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chord_debounce.sv
// chord_debounce: eight-key piano debouncer with a coalescing chord offer channel.
// Raw keys are synchronized, debounced per key, and any change of the debounced
// vector is offered downstream as one chord snapshot. Changes that arrive while
// an offer is stalled are merged, so only the newest vector is offered next.
module chord_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       t0,
  input  logic       t1,
  input  logic       t2,
  input  logic       t3,
  input  logic       t4,
  input  logic       t5,
  input  logic       t6,
  input  logic       t7,
  input  logic       chord_ready,
  output logic [7:0] chord,
  output logic       chord_valid,
  output logic [7:0] chord_live,
  output logic       any_key
);

  localparam int unsigned NKEYS = 8;
  localparam int unsigned CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_e;

  logic [NKEYS-1:0]            raw_c;
  logic [NKEYS-1:0]            s1_q, s1_d;
  logic [NKEYS-1:0]            s2_q, s2_d;
  logic [NKEYS-1:0]            deb_q, deb_d;
  logic [NKEYS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        chg_q, chg_d;
  logic                        any_q, any_d;
  logic                        pend_q, pend_d;
  logic                        valid_q, valid_d;
  logic [NKEYS-1:0]            chord_q, chord_d;
  state_e                      state_q, state_d;

  // t0 lands in the MSB so the vector reads left-to-right like the keyboard
  assign raw_c = {t0, t1, t2, t3, t4, t5, t6, t7};

  // Two-flop synchronizer feeding the debouncers
  always_comb begin
    s1_d = raw_c;
    s2_d = s1_q;
  end

  // Per-key debounce: flip only after DEB_CYCLES consecutive disagreeing samples
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < NKEYS; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    chg_d = (deb_d != deb_q);
    any_d = |deb_d;
  end

  // Offer FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Offer FSM next state: leave OFFER only on an accept with nothing newer to show
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (chg_q) state_d = ST_OFFER;
      ST_OFFER: if (chord_ready && !pend_q && !chg_q) state_d = ST_IDLE;
    endcase
  end

  // Offer FSM outputs: snapshot loading and coalescing of stalled changes
  always_comb begin
    chord_d = chord_q;
    pend_d  = pend_q;
    valid_d = (state_d == ST_OFFER);
    unique case (state_q)
      ST_IDLE: begin
        if (chg_q) chord_d = deb_q;
      end
      ST_OFFER: begin
        if (chord_ready) begin
          if (pend_q || chg_q) chord_d = deb_q;
          pend_d = 1'b0;
        end else if (chg_q) begin
          pend_d = 1'b1;
        end
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      chg_q   <= 1'b0;
      any_q   <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      chord_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      chg_q   <= chg_d;
      any_q   <= any_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      chord_q <= chord_d;
    end
  end

  assign chord       = chord_q;
  assign chord_valid = valid_q;
  assign chord_live  = deb_q;
  assign any_key     = any_q;

endmodule

// File: tb/tb_chord_debounce.sv
// Bench for chord_debounce: directed scenarios plus randomized key bouncing,
// scored against a behavioural model and a queue of expected offers.
module tb_chord_debounce;

  localparam int unsigned DEB = 4;

  logic       clk;
  logic       rst;
  logic       chord_ready;
  logic [7:0] keys;
  logic [7:0] chord;
  logic       chord_valid;
  logic [7:0] chord_live;
  logic       any_key;

  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  // Reference model state
  logic [7:0] m_s1, m_s2, m_deb, m_chord;
  logic       m_evt, m_offer, m_pend;
  logic [7:0] m_hist[$];
  logic [7:0] sb_q[$];

  chord_debounce #(.DEB_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst         (rst),
    .t0          (keys[7]),
    .t1          (keys[6]),
    .t2          (keys[5]),
    .t3          (keys[4]),
    .t4          (keys[3]),
    .t5          (keys[2]),
    .t6          (keys[1]),
    .t7          (keys[0]),
    .chord_ready (chord_ready),
    .chord       (chord),
    .chord_valid (chord_valid),
    .chord_live  (chord_live),
    .any_key     (any_key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a key's debounced level flips once its synchronized level
  // has disagreed with it for the last DEB samples; every new snapshot that gets
  // offered is queued for the monitor.
  initial begin : model_p
    logic [7:0] nd;
    logic       all_diff;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_chord = '0;
        m_evt = 1'b0; m_offer = 1'b0; m_pend = 1'b0;
        m_hist.delete();
        sb_q.delete();
      end else begin
        if (!m_offer) begin
          if (m_evt) begin
            m_chord = m_deb;
            m_offer = 1'b1;
            sb_q.push_back(m_deb);
          end
        end else if (chord_ready) begin
          if (m_pend || m_evt) begin
            m_chord = m_deb;
            m_pend  = 1'b0;
            sb_q.push_back(m_deb);
          end else begin
            m_offer = 1'b0;
          end
        end else if (m_evt) begin
          m_pend = 1'b1;
        end

        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        nd = m_deb;
        if (m_hist.size() == DEB) begin
          for (int k = 0; k < 8; k++) begin
            all_diff = 1'b1;
            for (int j = 0; j < int'(DEB); j++)
              if (m_hist[j][k] == m_deb[k]) all_diff = 1'b0;
            if (all_diff) nd[k] = ~m_deb[k];
          end
        end
        m_evt = (nd != m_deb);
        m_deb = nd;
        m_s2  = m_s1;
        m_s1  = keys;
      end
    end
  end

  // Monitor: per-cycle output comparison and offer scoreboard on each accept
  initial begin : monitor_p
    logic [7:0] exp_chord;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("chord_live", chord_live, m_deb);
        chk("any_key", any_key, |m_deb);
        chk("chord_valid", chord_valid, m_offer);
        chk("chord_hold", chord, m_chord);
        if (!rst && chord_valid && chord_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_pending", sb_q.size(), 1);
          end else begin
            exp_chord = sb_q.pop_front();
            chk("sb_chord", chord, exp_chord);
          end
        end
      end
    end
  end

  initial begin : driver_p
    keys        = '0;
    chord_ready = 1'b0;
    rst         = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    tick();
    chk("rst_chord", chord, 8'h00);
    chk("rst_valid", chord_valid, 1'b0);
    chk("rst_live", chord_live, 8'h00);
    chk("rst_any", any_key, 1'b0);
    rst = 1'b0;
    tick();
    tick();

    // Single press latency and one-cycle accept
    chord_ready = 1'b1;
    keys[7]     = 1'b1;
    tick();
    repeat (4) tick();
    chk("lat_live_e4", chord_live, 8'h00);
    tick();
    chk("lat_live_e5", chord_live, 8'h80);
    chk("lat_any_e5", any_key, 1'b1);
    chk("lat_valid_e5", chord_valid, 1'b0);
    tick();
    chk("lat_chord_e6", chord, 8'h80);
    chk("lat_valid_e6", chord_valid, 1'b1);
    tick();
    chk("lat_valid_e7", chord_valid, 1'b0);
    keys = '0;
    repeat (12) tick();

    // Short glitch is filtered
    keys[0] = 1'b1;
    repeat (3) tick();
    keys[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_live", chord_live, 8'h00);
      chk("glitch_valid", chord_valid, 1'b0);
    end

    // Backpressure coalesces a later press into one re-offer
    chord_ready = 1'b0;
    keys[5]     = 1'b1;
    repeat (8) tick();
    chk("bp_chord_first", chord, 8'h20);
    chk("bp_valid_first", chord_valid, 1'b1);
    keys[4] = 1'b1;
    repeat (8) tick();
    chk("bp_chord_held", chord, 8'h20);
    chk("bp_live", chord_live, 8'h30);
    chord_ready = 1'b1;
    tick();
    chk("bp_chord_reload", chord, 8'h30);
    chk("bp_valid_reload", chord_valid, 1'b1);
    tick();
    chk("bp_valid_idle", chord_valid, 1'b0);
    keys = '0;
    repeat (12) tick();

    // Simultaneous presses form one offer
    chord_ready = 1'b0;
    keys[6]     = 1'b1;
    keys[1]     = 1'b1;
    repeat (8) tick();
    chk("pair_chord", chord, 8'h42);
    chk("pair_valid", chord_valid, 1'b1);
    chord_ready = 1'b1;
    tick();
    chk("pair_single", chord_valid, 1'b0);
    keys = '0;
    repeat (12) tick();

    // Accept coinciding with a fresh change keeps the offer open
    chord_ready = 1'b0;
    keys[2]     = 1'b1;
    repeat (8) tick();
    chk("acc_chord_first", chord, 8'h04);
    keys[2] = 1'b0;
    keys[3] = 1'b1;
    repeat (6) tick();
    chk("acc_live_flip", chord_live, 8'h08);
    chk("acc_chord_old", chord, 8'h04);
    chord_ready = 1'b1;
    tick();
    chk("acc_chord_new", chord, 8'h08);
    chk("acc_valid_stay", chord_valid, 1'b1);
    tick();
    chk("acc_valid_idle", chord_valid, 1'b0);
    keys = '0;
    repeat (12) tick();

    // Reset mid-offer and mid-count discards everything
    chord_ready = 1'b0;
    keys[7]     = 1'b1;
    repeat (8) tick();
    chk("mrst_pre_valid", chord_valid, 1'b1);
    keys[6] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("mrst_chord", chord, 8'h00);
    chk("mrst_valid", chord_valid, 1'b0);
    chk("mrst_live", chord_live, 8'h00);
    chk("mrst_any", any_key, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mrst_quiet", chord_valid, 1'b0);
    end
    repeat (4) tick();
    chk("mrst_reoffer_chord", chord, 8'hc0);
    chk("mrst_reoffer_valid", chord_valid, 1'b1);
    chord_ready = 1'b1;
    keys        = '0;
    repeat (12) tick();

    // Randomized bouncing keys, bursty ready and rare resets
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 9) == 0) keys[k] = ~keys[k];
      chord_ready = ($urandom_range(0, 99) < 55);
      rst         = ($urandom_range(0, 599) == 0);
      tick();
    end

    // Drain outstanding offers
    rst         = 1'b0;
    chord_ready = 1'b1;
    repeat (20) tick();
    chk("drain_queue", sb_q.size(), 0);
    chk("drain_valid", chord_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
